// File: rtl/radix113_digit_serializer.sv
// -----------------------------------------------------------------------------
// radix113_digit_serializer
//
// Purpose
//   Converts a 36-bit unsigned word into base-113 digits, least-significant
//   digit first. One constant divider (div_36_113) is reused for every digit:
//   its quotient is fed back as the next dividend and its remainder is the
//   emitted digit. Only one word is in flight at a time.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_data is valid
//   in_ready   out  1      word can be accepted (high only when idle)
//   in_data    in   IN_W   word to convert
//   dig_valid  out  1      dig_data / dig_idx / dig_last are valid
//   dig_ready  in   1      downstream accepts the digit
//   dig_data   out  DIG_W  current base-113 digit (0..112)
//   dig_idx    out  3      digit position, 0 = least significant
//   dig_last   out  1      final digit of the current word
//   busy       out  1      conversion in progress
//
// IN_W is fixed at 36 by the divider; other values are not supported.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// div_36_113
//   Combinational divide of a 36-bit value by the constant 113.
//   n = q*113 + r, q is 30 bits wide, r < 113.
// -----------------------------------------------------------------------------
module div_36_113 (
  input  logic [35:0] n,
  output logic [29:0] q,
  output logic [6:0]  r
);

  logic [6:0] rem_s;
  logic [7:0] trial_s;

  // Restoring long division. The top 6 bits are at most 63 < 113, so they
  // never produce a quotient bit and seed the partial remainder directly.
  always_comb begin
    rem_s   = {1'b0, n[35:30]};
    trial_s = 8'd0;
    q       = 30'd0;
    for (int i = 29; i >= 0; i--) begin
      // rem_s < 113 always holds, so trial_s < 226 fits in 8 bits
      trial_s = {rem_s, n[i]};
      if (trial_s >= 8'd113) begin
        q[i]  = 1'b1;
        rem_s = 7'(trial_s - 8'd113);
      end else begin
        q[i]  = 1'b0;
        rem_s = trial_s[6:0];
      end
    end
    r = rem_s;
  end

endmodule

module radix113_digit_serializer #(
  parameter int IN_W       = 36,
  parameter int DIG_W      = 7,
  parameter int MAX_DIGITS = 6,
  parameter int FIX_DIGITS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [DIG_W-1:0] dig_data,
  output logic [2:0]       dig_idx,
  output logic             dig_last,
  output logic             busy
);

  localparam int Q_W = 30;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  work_q,  work_d;
  logic [Q_W-1:0]   q_q,     q_d;
  logic [DIG_W-1:0] r_q,     r_d;
  logic [2:0]       idx_q,   idx_d;

  logic [Q_W-1:0]   div_q_s;
  logic [DIG_W-1:0] div_r_s;
  logic             last_s;

  div_36_113 u_div (
    .n (work_q),
    .q (div_q_s),
    .r (div_r_s)
  );

  // Final-digit decision for the digit currently held in r_q
  always_comb begin
    if (FIX_DIGITS != 0) begin
      last_s = (idx_q == 3'(MAX_DIGITS - 1));
    end else begin
      last_s = (q_q == 30'd0);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    q_d     = q_q;
    r_d     = r_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          idx_d   = 3'd0;
          state_d = S_DIV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        q_d     = div_q_s;
        r_d     = div_r_s;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (dig_ready) begin
          if (last_s) begin
            state_d = S_IDLE;
          end else begin
            // quotient becomes the next dividend
            work_d  = {{(IN_W - Q_W){1'b0}}, q_q};
            idx_d   = idx_q + 3'd1;
            state_d = S_DIV;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      q_q     <= q_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decoded from registered state; digit fields are forced to zero
  // outside EMIT so nothing stale is visible when dig_valid is low.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    dig_valid = (state_q == S_EMIT);
    if (state_q == S_EMIT) begin
      dig_data = r_q;
      dig_idx  = idx_q;
      dig_last = last_s;
    end else begin
      dig_data = '0;
      dig_idx  = 3'd0;
      dig_last = 1'b0;
    end
  end

endmodule

// File: tb/tb_radix113_digit_serializer.sv
module tb_radix113_digit_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [35:0] in_data;
  logic        dig_ready;
  logic        sel;   // 0: FIX_DIGITS=0 instance, 1: FIX_DIGITS=1 instance

  logic       in_ready0, dig_valid0, dig_last0, busy0;
  logic [6:0] dig_data0;
  logic [2:0] dig_idx0;
  logic       in_ready1, dig_valid1, dig_last1, busy1;
  logic [6:0] dig_data1;
  logic [2:0] dig_idx1;

  logic       o_in_ready, o_dig_valid, o_dig_last, o_busy;
  logic [6:0] o_dig_data;
  logic [2:0] o_dig_idx;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  radix113_digit_serializer #(.FIX_DIGITS(0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & ~sel),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .dig_valid (dig_valid0),
    .dig_ready (dig_ready),
    .dig_data  (dig_data0),
    .dig_idx   (dig_idx0),
    .dig_last  (dig_last0),
    .busy      (busy0)
  );

  radix113_digit_serializer #(.FIX_DIGITS(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & sel),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .dig_valid (dig_valid1),
    .dig_ready (dig_ready),
    .dig_data  (dig_data1),
    .dig_idx   (dig_idx1),
    .dig_last  (dig_last1),
    .busy      (busy1)
  );

  assign o_in_ready  = sel ? in_ready1  : in_ready0;
  assign o_dig_valid = sel ? dig_valid1 : dig_valid0;
  assign o_dig_data  = sel ? dig_data1  : dig_data0;
  assign o_dig_idx   = sel ? dig_idx1   : dig_idx0;
  assign o_dig_last  = sel ? dig_last1  : dig_last0;
  assign o_busy      = sel ? busy1      : busy0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain repeated division by 113.
  task automatic model(input logic [35:0] word, input bit fix);
    longint n;
    n = longint'(word);
    exp_q.delete();
    if (fix) begin
      for (int i = 0; i < 6; i++) begin
        exp_q.push_back(int'(n % 113));
        n = n / 113;
      end
    end else begin
      do begin
        exp_q.push_back(int'(n % 113));
        n = n / 113;
      end while (n != 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  longint'(o_in_ready),  1);
    check({tag, "_dig_valid"}, longint'(o_dig_valid), 0);
    check({tag, "_dig_data"},  longint'(o_dig_data),  0);
    check({tag, "_dig_idx"},   longint'(o_dig_idx),   0);
    check({tag, "_dig_last"},  longint'(o_dig_last),  0);
    check({tag, "_busy"},      longint'(o_busy),      0);
  endtask

  // Convert one word; called and returning at a negedge with the DUT idle.
  task automatic convert(input string tag, input logic [35:0] word,
                         input bit fix, input int stall_pct, input bit hold_valid);
    int k, n, cyc, budget;
    bit rdy;
    sel = fix;
    model(word, fix);
    n = exp_q.size();
    check({tag, "_in_ready_idle"}, longint'(o_in_ready), 1);
    in_valid = 1'b1;
    in_data  = word;
    @(posedge clk); @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    check({tag, "_div_valid"}, longint'(o_dig_valid), 0);
    check({tag, "_div_ready"}, longint'(o_in_ready),  0);
    check({tag, "_div_busy"},  longint'(o_busy),      1);
    @(posedge clk); @(negedge clk);
    check({tag, "_latency_valid"}, longint'(o_dig_valid), 1);
    k = 0; cyc = 2; budget = 400;
    while (k < n && budget > 0) begin
      budget--;
      if (o_dig_valid) begin
        check({tag, "_data"}, longint'(o_dig_data), longint'(exp_q[k]));
        check({tag, "_idx"},  longint'(o_dig_idx),  longint'(k));
        check({tag, "_last"}, longint'(o_dig_last), longint'(k == n - 1));
        check({tag, "_range"}, longint'(o_dig_data < 7'd113), 1);
        check({tag, "_busy_emit"}, longint'(o_in_ready), 0);
        rdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
        dig_ready = rdy;
        @(posedge clk);
        if (rdy) k++;
      end else begin
        check({tag, "_busy_div"}, longint'(o_in_ready), 0);
        dig_ready = ($urandom_range(0, 1) == 1);
        @(posedge clk);
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_no_timeout"}, longint'(budget > 0), 1);
    dig_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_in_ready_after"}, longint'(o_in_ready), 1);
    check({tag, "_valid_after"},    longint'(o_dig_valid), 0);
    if (stall_pct == 0) check({tag, "_occupancy"}, longint'(cyc), longint'(2 * n + 1));
  endtask

  initial begin
    logic [35:0] w;
    int budget;
    sel = 1'b0; in_valid = 1'b0; in_data = 36'd0; dig_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    convert("t1_113",  36'd113,          1'b0, 0, 1'b0);
    convert("t2_zero", 36'd0,            1'b0, 0, 1'b0);
    convert("t3_max",  36'hF_FFFF_FFFF,  1'b0, 0, 1'b0);
    convert("t4_fix",  36'd113,          1'b1, 0, 1'b0);
    convert("t5_stall", 36'hF_FFFF_FFFF, 1'b0, 50, 1'b1);
    convert("fix_zero", 36'd0,           1'b1, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      w = {4'($urandom_range(0, 15)), 32'($urandom)};
      convert("rnd0", w, 1'b0, (i % 2) * 40, i[0]);
      w = 36'($urandom_range(0, 20000));
      convert("rnd1", w, 1'b1, (i % 3) * 30, 1'b0);
    end

    // Test 6: asynchronous reset while emitting digit 2 of the max word.
    sel = 1'b0;
    in_valid = 1'b1; in_data = 36'hF_FFFF_FFFF;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    dig_ready = 1'b1;
    budget = 50;
    while (!(o_dig_valid && o_dig_idx == 3'd2) && budget > 0) begin
      budget--;
      @(posedge clk); @(negedge clk);
    end
    check("t6_reach_idx2", longint'(budget > 0), 1);
    check("t6_idx2_data", longint'(o_dig_data), 5);
    dig_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    check_reset_outputs("t6_held");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_no_partial", longint'(o_dig_valid), 0);
    end
    convert("t6_226", 36'd226, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
